// File: rtl/lfsr_gen_if.sv
// lfsr_gen_if: bundle of the control and observation signals of lfsr_gen.
//
// Ports (signals carried by the interface):
//   load, seed          seed load request and value
//   en                  free-running step enable
//   burst_start,        burst request and its step count
//   burst_len
//   burst_busy          burst in progress (registered)
//   burst_done          one-cycle pulse after the final burst step
//   q                   serial PRBS bit (feedback of current state)
//   state               current LFSR state
//   wrap                one-cycle pulse when the sequence returns to its seed
//   seed_err            sticky flag: last load carried an all-zero seed
//   fsm_run             debug view of the burst FSM (1 = RUN)
//
// Handshake: burst_start is a single-cycle request sampled on the rising
// edge. It is accepted only while burst_busy is low, no load is present and
// burst_len is nonzero; otherwise it is silently dropped. burst_busy acts as
// the "not ready" indication for further requests, and burst_done marks
// completion. load and en have no handshake and act on the edge they are
// sampled high.
interface lfsr_gen_if #(
  parameter int WIDTH = 16,
  parameter int CNT_W = 16
);
  logic             load;
  logic [WIDTH-1:0] seed;
  logic             en;
  logic             burst_start;
  logic [CNT_W-1:0] burst_len;
  logic             burst_busy;
  logic             burst_done;
  logic             q;
  logic [WIDTH-1:0] state;
  logic             wrap;
  logic             seed_err;
  logic             fsm_run;

  modport master (
    output load, seed, en, burst_start, burst_len,
    input  burst_busy, burst_done, q, state, wrap, seed_err, fsm_run
  );

  modport slave (
    input  load, seed, en, burst_start, burst_len,
    output burst_busy, burst_done, q, state, wrap, seed_err, fsm_run
  );
endinterface

// File: rtl/lfsr_gen.sv
// lfsr_gen: parametrised Fibonacci LFSR with seed load, free-run enable,
// counted bursts with a done pulse, wrap detection and zero-seed guard.
//
// Ports:
//   clk   rising-edge clock
//   rst   synchronous active-high reset
//   bus   lfsr_gen_if.slave (load/seed/en/burst_* in; state/q/flags out)
module lfsr_gen #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] TAPS       = 16'hD008,
  parameter logic [WIDTH-1:0] RESET_SEED = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter int               CNT_W      = 16
) (
  input logic        clk,
  input logic        rst,
  lfsr_gen_if.slave  bus
);

  typedef enum logic {IDLE, RUN} fsm_t;

  localparam logic [WIDTH-1:0] ONE_SEED = {{(WIDTH-1){1'b0}}, 1'b1};

  fsm_t             fsm_r, fsm_next;
  logic [CNT_W-1:0] rem_r, rem_next;
  logic             done_next;
  logic [WIDTH-1:0] state_r, ref_seed_r, state_step;
  logic             done_r, wrap_r, seed_err_r;
  logic             fb, step_now;

  assign fb         = ^(state_r & TAPS);
  assign state_step = {state_r[WIDTH-2:0], fb};
  // en during a burst is absorbed: at most one step per cycle either way.
  assign step_now   = bus.en | (fsm_r == RUN);

  // Burst FSM next-state. A load overrides everything (aborts a burst and
  // blocks a coincident start); reset is handled in the register process.
  always_comb begin
    fsm_next  = fsm_r;
    rem_next  = rem_r;
    done_next = 1'b0;
    unique case (fsm_r)
      IDLE: begin
        if (bus.burst_start && (bus.burst_len != '0)) begin
          fsm_next = RUN;
          rem_next = bus.burst_len;
        end
      end
      RUN: begin
        rem_next = rem_r - CNT_W'(1);
        if (rem_r == CNT_W'(1)) begin
          fsm_next  = IDLE;
          done_next = 1'b1;
        end
      end
      default: fsm_next = IDLE;
    endcase
    if (bus.load) begin
      fsm_next  = IDLE;
      rem_next  = '0;
      done_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_r      <= IDLE;
      rem_r      <= '0;
      state_r    <= RESET_SEED;
      ref_seed_r <= RESET_SEED;
      done_r     <= 1'b0;
      wrap_r     <= 1'b0;
      seed_err_r <= 1'b0;
    end else begin
      fsm_r  <= fsm_next;
      rem_r  <= rem_next;
      done_r <= done_next;
      if (bus.load) begin
        wrap_r <= 1'b0;
        // A zero seed would lock the register; substitute 1 and flag it.
        if (bus.seed == '0) begin
          state_r    <= ONE_SEED;
          ref_seed_r <= ONE_SEED;
          seed_err_r <= 1'b1;
        end else begin
          state_r    <= bus.seed;
          ref_seed_r <= bus.seed;
          seed_err_r <= 1'b0;
        end
      end else if (step_now) begin
        state_r <= state_step;
        wrap_r  <= (state_step == ref_seed_r);
      end else begin
        wrap_r <= 1'b0;
      end
    end
  end

  assign bus.state      = state_r;
  assign bus.q          = fb;
  assign bus.burst_busy = (fsm_r == RUN);
  assign bus.burst_done = done_r;
  assign bus.wrap       = wrap_r;
  assign bus.seed_err   = seed_err_r;
  assign bus.fsm_run    = (fsm_r == RUN);

endmodule

// File: doc/lfsr_gen.md
Name: lfsr_gen

Overview:
Parametrised Fibonacci LFSR pseudo-random generator and the next generation of the team's fixed 4-bit LFSR.
- Width and tap polynomial are set by parameters.
- Supports seed load, free-running step enable, counted burst mode with a done pulse, sequence-wrap detection, and zero-seed protection.
- Feeds test-pattern, scrambler and BIST logic that needs a word-wide or serial PRBS source.

Parameters:
WIDTH, 16, LFSR register width in bits (>=3)
TAPS, 16'hD008, feedback mask; bit i set means state[i] is XORed into feedback (default x^16+x^15+x^13+x^4+1)
RESET_SEED, 1, state value after reset (must be nonzero)
CNT_W, 16, width of burst length counter

Ports:
clk  input  1  clock, rising-edge
rst  input  1  synchronous active-high reset
load  input  1  load seed into state this cycle
seed  input  WIDTH  seed value for load
en  input  1  free-running step enable
burst_start  input  1  request a burst of burst_len steps
burst_len  input  CNT_W  number of steps in burst
burst_busy  output  1  burst in progress
burst_done  output  1  one-cycle pulse after final burst step
q  output  1  serial PRBS bit = feedback of current state
state  output  WIDTH  current LFSR state
wrap  output  1  one-cycle pulse: sequence returned to reference seed
seed_err  output  1  sticky: last load had all-zero seed

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk, rst).
- fb = XOR of (state & TAPS); combinational.
- q = fb, combinational from current state.
- Step: state <= {state[WIDTH-2:0], fb}. At most one step per cycle.
- step_now = en OR (FSM == RUN).
- Priority per edge: rst > load > step.
- Reset values:
  - state = RESET_SEED
  - ref_seed = RESET_SEED
  - FSM = IDLE, remaining count = 0
  - burst_busy, burst_done, wrap, seed_err = 0
- Load:
  - Nonzero seed: state <= seed, ref_seed <= seed, seed_err <= 0.
  - seed == 0: state <= 1, ref_seed <= 1, seed_err <= 1. seed_err holds until the next nonzero load or reset.
  - A load never steps in the same cycle and never asserts wrap.
  - Load while FSM == RUN aborts the burst: FSM -> IDLE, burst_busy drops next cycle, no burst_done.
- FSM, IDLE:
  - burst_start with burst_len != 0: remaining <= burst_len, FSM -> RUN.
  - burst_start with burst_len == 0: ignored, no done pulse.
  - burst_start coincident with load: load applies, burst not started.
- FSM, RUN:
  - burst_busy = 1 (registered; high exactly the N cycles in which steps occur).
  - Steps every cycle; remaining decrements on each step.
  - On the edge performing the final step (remaining == 1): FSM -> IDLE, burst_done <= 1 for one cycle.
  - burst_start in RUN is ignored. en in RUN adds no extra steps.
  - A burst of N steps advances state exactly N times.
- wrap: registered pulse, set on a step edge whose next state equals ref_seed; otherwise 0.
- Lockup: the all-zero state is unreachable (zero-seed guard plus XOR feedback from a nonzero state).
- Reset mid-burst: all state returns to reset values, no done pulse.
- Implementation must synthesise for any WIDTH/TAPS; no hard-coded bit positions.

Test Plan:
- WIDTH=4, TAPS=4'hC, after rst: state=0001, q=0. With en=1, states are 0010, 0100, 1001, 0011, 0110 on successive edges; q=1 while state=0100.
- WIDTH=4, TAPS=4'hC, en=1 from seed 0001: wrap pulses once, on the 15th step (state back to 0001); all 15 nonzero states are visited exactly once.
- Default params, load seed=16'hACE1, burst_start with burst_len=5, en=0: burst_busy high 5 cycles, state advances exactly 5 steps, burst_done pulses one cycle after the final step. A further burst_start mid-burst is ignored.
- load seed=0: state=0001, seed_err=1. Then load seed=16'h0005: seed_err=0, state=0005.
- Burst of 10 with load of 16'h1234 asserted on cycle 4: state=1234, burst_busy low next cycle, burst_done never pulses. burst_len=0 start: no busy, no done.
- rst asserted mid-burst simultaneously with load and en: state=RESET_SEED, all outputs 0 next cycle. Default params free-run: wrap period = 65535 steps.
